// File: rtl/vpu_pkg.sv
// Shared definitions for the VPU blitter: VRAM geometry, blitter FSM states,
// register offsets of the blitter window and CTRL/STATUS bit positions.
package vpu_pkg;

    localparam int VRAM_AW = 13;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } blit_state_e;

    localparam logic [2:0] BLT_SRC_H = 3'd0;
    localparam logic [2:0] BLT_SRC_L = 3'd1;
    localparam logic [2:0] BLT_DST_H = 3'd2;
    localparam logic [2:0] BLT_DST_L = 3'd3;
    localparam logic [2:0] BLT_CNT_H = 3'd4;
    localparam logic [2:0] BLT_CNT_L = 3'd5;
    localparam logic [2:0] BLT_FILL  = 3'd6;
    localparam logic [2:0] BLT_CTRL  = 3'd7;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_DIR   = 2;
    localparam int CTRL_KEY   = 3;
    localparam int CTRL_IEN   = 6;

endpackage

// File: rtl/vpu_vram_arb.sv
// VRAM port-A mux with fixed CPU priority.
// Ports: cpu_* = CPU data-window request; eng_* = blit engine request;
//        vram_* = muxed port to the RAM; eng_gnt = engine beat accepted.
// Engine handshake: eng_req is the engine's valid and eng_gnt its ready. A beat
// (read address or write) transfers in a cycle where both are high; while
// eng_gnt is low the engine holds address, data and write enable unchanged.
module vpu_vram_arb
    import vpu_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = 8
) (
    input  logic          cpu_vreq,
    input  logic          cpu_vwe,
    input  logic [AW-1:0] cpu_vaddr,
    input  logic [DW-1:0] cpu_vwdata,
    input  logic          eng_req,
    input  logic          eng_we,
    input  logic [AW-1:0] eng_addr,
    input  logic [DW-1:0] eng_wdata,
    output logic [AW-1:0] vram_addr,
    output logic [DW-1:0] vram_wdata,
    output logic          vram_we,
    output logic          eng_gnt
);

    always_comb begin
        vram_addr  = eng_addr;
        vram_wdata = eng_wdata;
        vram_we    = eng_req && eng_we;
        eng_gnt    = eng_req;
        if (cpu_vreq) begin
            vram_addr  = cpu_vaddr;
            vram_wdata = cpu_vwdata;
            vram_we    = cpu_vwe;
            eng_gnt    = 1'b0;
        end
    end

endmodule

// File: rtl/vpu_blit_ctl.sv
// VRAM port-A scheduler and fill/copy block-transfer engine.
// Ports: clk/rst_n (async active-low); AD/DI/DO/rw/cs register window (DO registered);
//        irq completion level; cpu_v* CPU VRAM request; vram_* muxed RAM port
//        (vram_rdata valid one cycle after the address); busy engine active.
// Optional build macro VPU_BLIT_KEY_EN: CTRL bit3 KEY skips copy bytes equal to FILL.
// The FSM state is held in the 'state' signal (blit_state_e) for observation.
module vpu_blit_ctl
    import vpu_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    AD,
    input  logic [7:0]    DI,
    output logic [7:0]    DO,
    input  logic          rw,
    input  logic          cs,
    output logic          irq,
    input  logic          cpu_vreq,
    input  logic          cpu_vwe,
    input  logic [AW-1:0] cpu_vaddr,
    input  logic [DW-1:0] cpu_vwdata,
    output logic [AW-1:0] vram_addr,
    output logic [DW-1:0] vram_wdata,
    output logic          vram_we,
    input  logic [DW-1:0] vram_rdata,
    output logic          busy
);

    blit_state_e   state, state_nx;

    // Programmed registers (read back unchanged) and working copies.
    logic [AW-1:0] src_r, dst_r, cnt_r;
    logic [AW-1:0] w_src, w_dst, w_cnt;
    logic [DW-1:0] fill_r, data_r;
    logic          ien_r, mode_r, dir_r, irq_r;
    logic [7:0]    do_r;

    logic          bus_wr, bus_rd, start_go, cnt_zero;
    logic          eng_req, eng_we, eng_gnt, wr_step, skip, key_bit;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata;
    logic [15:0]   src_x, dst_x, cnt_x;
    logic [7:0]    stat;

`ifdef VPU_BLIT_KEY_EN
    logic          key_r;
    assign skip    = mode_r && key_r && (data_r == fill_r);
    assign key_bit = key_r;
`else
    assign skip    = 1'b0;
    assign key_bit = 1'b0;
`endif

    assign bus_wr   = cs && !rw;
    assign bus_rd   = cs && rw;
    assign busy     = (state == ST_RD) || (state == ST_CAP) || (state == ST_WR);
    assign start_go = bus_wr && (AD == BLT_CTRL) && DI[CTRL_START] && !busy;
    assign cnt_zero = (cnt_r == '0);

    assign eng_req   = (state == ST_RD) || (state == ST_WR);
    assign eng_we    = (state == ST_WR) && !skip;
    assign eng_addr  = (state == ST_RD) ? w_src : w_dst;
    assign eng_wdata = mode_r ? data_r : fill_r;
    // A granted WR beat advances even when a keyed byte suppresses the write.
    assign wr_step   = (state == ST_WR) && eng_gnt;

    assign src_x = {{(16-AW){1'b0}}, src_r};
    assign dst_x = {{(16-AW){1'b0}}, dst_r};
    assign cnt_x = {{(16-AW){1'b0}}, cnt_r};
    assign stat  = {irq_r, ien_r, 2'b00, key_bit, 1'b0, mode_r, busy};

    assign DO  = do_r;
    assign irq = irq_r;

    vpu_vram_arb #(.AW(AW), .DW(DW)) u_arb (
        .cpu_vreq   (cpu_vreq),
        .cpu_vwe    (cpu_vwe),
        .cpu_vaddr  (cpu_vaddr),
        .cpu_vwdata (cpu_vwdata),
        .eng_req    (eng_req),
        .eng_we     (eng_we),
        .eng_addr   (eng_addr),
        .eng_wdata  (eng_wdata),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .eng_gnt    (eng_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            // DONE is not busy, so it accepts a new START just like IDLE.
            ST_IDLE, ST_DONE: begin
                state_nx = ST_IDLE;
                if (start_go && !cnt_zero) state_nx = DI[CTRL_MODE] ? ST_RD : ST_WR;
            end
            ST_RD:  if (eng_gnt) state_nx = ST_CAP;
            ST_CAP: state_nx = ST_WR;
            ST_WR: begin
                if (eng_gnt) begin
                    if (w_cnt == AW'(1)) state_nx = ST_DONE;
                    else if (mode_r)     state_nx = ST_RD;
                    else                 state_nx = ST_WR;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_r  <= '0;
            dst_r  <= '0;
            cnt_r  <= '0;
            fill_r <= '0;
            ien_r  <= 1'b0;
            mode_r <= 1'b0;
            dir_r  <= 1'b0;
`ifdef VPU_BLIT_KEY_EN
            key_r  <= 1'b0;
`endif
            w_src  <= '0;
            w_dst  <= '0;
            w_cnt  <= '0;
            data_r <= '0;
            irq_r  <= 1'b0;
            do_r   <= '0;
        end else begin
            if (bus_wr && !busy) begin
                case (AD)
                    BLT_SRC_H: src_r[AW-1:8] <= DI[AW-9:0];
                    BLT_SRC_L: src_r[7:0]    <= DI;
                    BLT_DST_H: dst_r[AW-1:8] <= DI[AW-9:0];
                    BLT_DST_L: dst_r[7:0]    <= DI;
                    BLT_CNT_H: cnt_r[AW-1:8] <= DI[AW-9:0];
                    BLT_CNT_L: cnt_r[7:0]    <= DI;
                    BLT_FILL:  fill_r        <= DI;
                    default: begin
                        ien_r  <= DI[CTRL_IEN];
                        mode_r <= DI[CTRL_MODE];
                        dir_r  <= DI[CTRL_DIR];
`ifdef VPU_BLIT_KEY_EN
                        key_r  <= DI[CTRL_KEY];
`endif
                    end
                endcase
            end

            if (start_go) begin
                w_src <= src_r;
                w_dst <= dst_r;
                w_cnt <= cnt_r;
            end

            // The RAM answers a cycle after RD, independent of who owns the port now.
            if (state == ST_CAP) data_r <= vram_rdata;

            if (wr_step) begin
                w_src <= dir_r ? (w_src - AW'(1)) : (w_src + AW'(1));
                w_dst <= dir_r ? (w_dst - AW'(1)) : (w_dst + AW'(1));
                w_cnt <= w_cnt - AW'(1);
            end

            // Completion (or a zero-length START) sets IRQ; set beats a same-cycle read clear.
            if ((state == ST_DONE && ien_r) || (start_go && cnt_zero && DI[CTRL_IEN]))
                irq_r <= 1'b1;
            else if (bus_rd && AD == BLT_CTRL)
                irq_r <= 1'b0;

            if (bus_rd) begin
                case (AD)
                    BLT_SRC_H: do_r <= src_x[15:8];
                    BLT_SRC_L: do_r <= src_x[7:0];
                    BLT_DST_H: do_r <= dst_x[15:8];
                    BLT_DST_L: do_r <= dst_x[7:0];
                    BLT_CNT_H: do_r <= cnt_x[15:8];
                    BLT_CNT_L: do_r <= cnt_x[7:0];
                    BLT_FILL:  do_r <= fill_r;
                    default:   do_r <= stat;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vpu_blit_ctl.sv
module tb_vpu_blit_ctl;

`ifdef VPU_BLIT_KEY_EN
    localparam bit KEY_HW = 1'b1;
`else
    localparam bit KEY_HW = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  ad;
    logic [7:0]  di;
    logic [7:0]  do_bus;
    logic        rw, cs, irq, busy;
    logic        cpu_vreq, cpu_vwe;
    logic [12:0] cpu_vaddr;
    logic [7:0]  cpu_vwdata;
    logic [12:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [7:0]  vram_rdata;

    vpu_blit_ctl dut (
        .clk(clk), .rst_n(rst_n), .AD(ad), .DI(di), .DO(do_bus), .rw(rw), .cs(cs),
        .irq(irq), .cpu_vreq(cpu_vreq), .cpu_vwe(cpu_vwe), .cpu_vaddr(cpu_vaddr),
        .cpu_vwdata(cpu_vwdata), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_we(vram_we), .vram_rdata(vram_rdata), .busy(busy)
    );

    // Synchronous VRAM model
    logic [7:0] mem    [0:8191];
    logic [7:0] shadow [0:8191];
    always @(posedge clk) begin
        if (vram_we === 1'b1) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- port monitor (records only) ----------------
    int          eng_wr_n = 0;
    int          cpu_wr_n = 0;
    int          arb_err  = 0;
    logic [20:0] obs_a [int];
    int          obs_c [int];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && cpu_vreq === 1'b1) begin
            if (vram_addr !== cpu_vaddr || vram_we !== cpu_vwe ||
                (cpu_vwe && vram_wdata !== cpu_vwdata))
                arb_err++;
            if (cpu_vwe) cpu_wr_n++;
        end else if (vram_we === 1'b1) begin
            obs_a[eng_wr_n] = {vram_addr, vram_wdata};
            obs_c[eng_wr_n] = cyc;
            eng_wr_n++;
        end
    end

    // ---------------- scoreboard ----------------
    logic [20:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cs = 1'b1; rw = 1'b0; ad = a; di = d;
        @(posedge clk); #1;
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        cs = 1'b1; rw = 1'b1; ad = a;
        @(posedge clk); #1;
        d = do_bus;
        cs = 1'b0;
    endtask

    task automatic cpu_write(input logic [12:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_vreq = 1'b1; cpu_vwe = 1'b1; cpu_vaddr = a; cpu_vwdata = d;
        @(posedge clk); #1;
        cpu_vreq = 1'b0; cpu_vwe = 1'b0;
    endtask

    task automatic program_op(input logic [12:0] src, input logic [12:0] dst,
                              input logic [12:0] cnt, input logic [7:0] fill);
        reg_wr(3'd0, {3'b0, src[12:8]});
        reg_wr(3'd1, src[7:0]);
        reg_wr(3'd2, {3'b0, dst[12:8]});
        reg_wr(3'd3, dst[7:0]);
        reg_wr(3'd4, {3'b0, cnt[12:8]});
        reg_wr(3'd5, cnt[7:0]);
        reg_wr(3'd6, fill);
    endtask

    task automatic start_op(input bit mode, input bit dir, input bit key, input bit ien);
        reg_wr(3'd7, {1'b0, ien, 2'b00, key, dir, mode, 1'b1});
    endtask

    // Reference: the transfer as a byte-by-byte loop over a private memory image.
    task automatic model_op(input logic [12:0] src, input logic [12:0] dst, input int cnt,
                            input logic [7:0] fill, input bit mode, input bit dir, input bit key);
        logic [12:0] s, d;
        logic [7:0]  b;
        shadow = mem;
        s = src; d = dst;
        for (int i = 0; i < cnt; i++) begin
            b = mode ? shadow[s] : fill;
            if (!(mode && key && b == fill)) begin
                shadow[d] = b;
                exp_q.push_back({d, b});
            end
            s = dir ? s - 13'd1 : s + 13'd1;
            d = dir ? d - 13'd1 : d + 13'd1;
        end
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(posedge clk); #1;
            if (rnd) begin
                cpu_vreq   = ($urandom_range(0, 2) == 0);
                cpu_vwe    = 1'b0;
                cpu_vaddr  = 13'($urandom);
                cpu_vwdata = 8'($urandom);
            end
            n++;
        end
        cpu_vreq = 1'b0;
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic compare_op(input string tag, input int base);
        int n = eng_wr_n - base;
        check({tag, "_wr_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check({tag, "_wr"}, 32'(obs_a[base + i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    task automatic run_op(input string tag, input logic [12:0] src, input logic [12:0] dst,
                          input logic [12:0] cnt, input logic [7:0] fill, input bit mode,
                          input bit dir, input bit key, input bit ien, input bit rnd,
                          output int base);
        int arb0;
        program_op(src, dst, cnt, fill);
        model_op(src, dst, int'(cnt), fill, mode, dir, key);
        base = eng_wr_n;
        arb0 = arb_err;
        start_op(mode, dir, key, ien);
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        wait_idle(rnd);
        compare_op(tag, base);
        check({tag, "_arb"}, 32'(arb_err - arb0), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0]  rd;
    logic [7:0]  b0, b1, b2;
    int          base, arb0, cw0, n;
    logic [12:0] rsrc, rdst, rcnt;
    logic [7:0]  rfill;
    bit          rmode, rdir, rien, rkey;

    initial begin
        rst_n = 1'b0; cs = 1'b0; rw = 1'b1; ad = '0; di = '0;
        cpu_vreq = 1'b0; cpu_vwe = 1'b0; cpu_vaddr = '0; cpu_vwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_do", 32'(do_bus), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_we", 32'(vram_we), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reg_rd(3'(i), rd);
            check("rst_reg", 32'(rd), 32'd0);
        end

        // Fill 4 bytes at $0100 with IRQ
        run_op("fill", 13'h0000, 13'h0100, 13'd4, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, base);
        if (eng_wr_n - base >= 4)
            check("fill_span", 32'(obs_c[base + 3] - obs_c[base]), 32'd3);
        @(posedge clk); #1;
        check("fill_irq", 32'(irq), 32'd1);
        reg_rd(3'd7, rd);
        check("fill_stat", 32'(rd), 32'hC0);
        check("fill_irq_clr", 32'(irq), 32'd0);
        reg_rd(3'd2, rd);
        check("fill_dst_h", 32'(rd), 32'h01);
        reg_rd(3'd5, rd);
        check("fill_cnt_l", 32'(rd), 32'h04);

        // Copy, decrementing across the address wrap
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        cpu_write(13'h0001, b1);
        cpu_write(13'h0000, b0);
        cpu_write(13'h1FFF, b2);
        run_op("copy_dec", 13'h0001, 13'h1000, 13'd3, 8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, base);
        if (eng_wr_n - base >= 3)
            check("copy_span", 32'(obs_c[base + 2] - obs_c[base]), 32'd6);
        @(posedge clk); #1;
        check("copy_mem0", 32'(mem[13'h1000]), 32'(b1));
        check("copy_mem1", 32'(mem[13'h0FFF]), 32'(b0));
        check("copy_mem2", 32'(mem[13'h0FFE]), 32'(b2));
        check("copy_irq", 32'(irq), 32'd0);

        // Fill with 5 cycles of CPU writes in the middle
        program_op(13'h0000, 13'h0200, 13'd8, 8'h5A);
        model_op(13'h0000, 13'h0200, 8, 8'h5A, 1'b0, 1'b0, 1'b0);
        base = eng_wr_n; arb0 = arb_err; cw0 = cpu_wr_n;
        start_op(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cpu_vreq = 1'b1; cpu_vwe = 1'b1;
            cpu_vaddr = 13'h1500 + 13'(i); cpu_vwdata = 8'hC0 + 8'(i);
        end
        @(posedge clk); #1;
        cpu_vreq = 1'b0; cpu_vwe = 1'b0;
        check("cont_busy_mid", 32'(busy), 32'd1);
        wait_idle(1'b0);
        compare_op("cont", base);
        if (eng_wr_n - base >= 8)
            check("cont_span", 32'(obs_c[base + 7] - obs_c[base]), 32'd12);
        check("cont_cpu_wr", 32'(cpu_wr_n - cw0), 32'd5);
        check("cont_arb", 32'(arb_err - arb0), 32'd0);
        @(posedge clk); #1;
        check("cont_cpu_mem0", 32'(mem[13'h1500]), 32'hC0);
        check("cont_cpu_mem4", 32'(mem[13'h1504]), 32'hC4);

        // COUNT = 0 with IEN
        program_op(13'h0123, 13'h0456, 13'd0, 8'h11);
        base = eng_wr_n;
        start_op(1'b0, 1'b0, 1'b0, 1'b1);
        check("zero_irq", 32'(irq), 32'd1);
        n = 0;
        repeat (4) begin
            if (busy !== 1'b0) n++;
            @(posedge clk); #1;
        end
        check("zero_busy_seen", 32'(n), 32'd0);
        check("zero_writes", 32'(eng_wr_n - base), 32'd0);
        reg_rd(3'd7, rd);
        check("zero_stat", 32'(rd), 32'hC0);

        // Register writes and START while busy are ignored
        program_op(13'h0000, 13'h0300, 13'd10, 8'h3C);
        model_op(13'h0000, 13'h0300, 10, 8'h3C, 1'b0, 1'b0, 1'b0);
        base = eng_wr_n;
        start_op(1'b0, 1'b0, 1'b0, 1'b0);
        reg_wr(3'd3, 8'h77);
        reg_wr(3'd7, 8'h43);
        check("bw_busy_mid", 32'(busy), 32'd1);
        wait_idle(1'b0);
        compare_op("bw", base);
        reg_rd(3'd3, rd);
        check("bw_dst_l", 32'(rd), 32'h00);
        reg_rd(3'd2, rd);
        check("bw_dst_h", 32'(rd), 32'h03);
        reg_rd(3'd7, rd);
        check("bw_stat", 32'(rd), 32'h00);
        check("bw_irq", 32'(irq), 32'd0);

        // Optional KEY bit readback
        reg_wr(3'd7, 8'h08);
        reg_rd(3'd7, rd);
        check("key_bit", 32'(rd), KEY_HW ? 32'h08 : 32'h00);

        // Overlapping forward copy is literal
        for (int i = 0; i < 6; i++) cpu_write(13'h0600 + 13'(i), 8'($urandom));
        run_op("overlap", 13'h0600, 13'h0602, 13'd6, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, base);

        // Randomized transfers with random CPU read contention
        for (int t = 0; t < 8; t++) begin
            rsrc  = 13'($urandom);
            rdst  = 13'($urandom);
            rcnt  = 13'($urandom_range(1, 12));
            rfill = 8'($urandom);
            rmode = 1'($urandom_range(0, 1));
            rdir  = 1'($urandom_range(0, 1));
            rien  = 1'($urandom_range(0, 1));
            rkey  = KEY_HW ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rmode) begin
                for (int i = 0; i < int'(rcnt); i++)
                    cpu_write(rdir ? rsrc - 13'(i) : rsrc + 13'(i),
                              ($urandom_range(0, 3) == 0) ? rfill : 8'($urandom));
            end
            run_op("rand", rsrc, rdst, rcnt, rfill, rmode, rdir, rkey, rien, 1'b1, base);
            @(posedge clk); #1;
            check("rand_irq", 32'(irq), 32'(rien));
            reg_rd(3'd7, rd);
            check("rand_stat", 32'(rd), 32'({rien, rien, 2'b00, rkey, 1'b0, rmode, 1'b0}));
            check("rand_irq_clr", 32'(irq), 32'd0);
            reg_rd(3'd1, rd);
            check("rand_src_l", 32'(rd), 32'(rsrc[7:0]));
            reg_rd(3'd4, rd);
            check("rand_cnt_h", 32'(rd), 32'({3'b0, rcnt[12:8]}));
        end

        // Reset in the middle of a copy
        for (int i = 0; i < 10; i++) cpu_write(13'h0400 + 13'(i), 8'($urandom));
        program_op(13'h0400, 13'h0800, 13'd10, 8'h00);
        base = eng_wr_n;
        start_op(1'b1, 1'b0, 1'b0, 1'b1);
        n = 0;
        while ((eng_wr_n - base) < 2 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst_mid_reach", 32'((eng_wr_n - base) >= 2), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", 32'(vram_we), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        n = eng_wr_n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_nowr", 32'(eng_wr_n - n), 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        check("rst_mid_do", 32'(do_bus), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reg_rd(3'(i), rd);
            check("rst_mid_reg", 32'(rd), 32'd0);
        end
        check("rst_mid_irq_after", 32'(irq), 32'd0);
        check("rst_mid_nowr_after", 32'(eng_wr_n - n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vpu_blit_ctl.md
Name: vpu_blit_ctl

Overview:
- VRAM port-A scheduler and block-transfer engine for the VPU.
- Arbitrates the 8 KB VRAM write/read port between the CPU data-window path (fixed priority) and an internal fill/copy engine.
- Register-programmed through a small bus window, alongside the VPU registers; raises an IRQ on completion.

Parameters:
- AW, 13, VRAM address width (8 KB); all address and count arithmetic is modulo 2^AW.
- DW, 8, VRAM data width.

Ports:
- clk  in  1  system clock; the single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- AD  in  3  register select.
- DI  in  8  bus write data.
- DO  out  8  bus read data; registered.
- rw  in  1  1 = read, 0 = write.
- cs  in  1  register window select; one access per cycle while high.
- irq  out  1  completion interrupt, level.
- cpu_vreq  in  1  CPU path requests the VRAM port this cycle.
- cpu_vwe  in  1  CPU access is a write.
- cpu_vaddr  in  AW  CPU VRAM address.
- cpu_vwdata  in  DW  CPU write data.
- vram_addr  out  AW  muxed VRAM address.
- vram_wdata  out  DW  muxed VRAM write data.
- vram_we  out  1  muxed VRAM write enable.
- vram_rdata  in  DW  synchronous RAM output; valid the cycle after the address is presented.
- busy  out  1  engine active.

Behaviour:
- Register map:
  - $0/$1: SRC MSB[4:0]/LSB.
  - $2/$3: DST MSB[4:0]/LSB.
  - $4/$5: COUNT MSB[4:0]/LSB.
  - $6: FILL value.
  - $7 write: bit0 START, bit1 MODE (0 = fill, 1 = copy), bit2 DIR (0 = increment, 1 = decrement), bit6 IEN.
  - $7 read: {IRQ, IEN, 4'b0, MODE_latched, BUSY}. Reading $7 clears IRQ.
  - All registers read back. DO updates on the posedge with cs&&rw.
- Reset values: SRC = DST = COUNT = 0, FILL = 0, IEN = 0, MODE = 0, DIR = 0, IRQ = 0, DO = 0, busy = 0, state IDLE, vram_we = 0.
- Writes to $0–$6 while BUSY are ignored. START while BUSY is ignored. MODE/DIR/IEN in the same $7 write still update only when not BUSY.
- START with COUNT = 0: no VRAM access; IRQ <= IEN the next cycle; busy never asserts.
- FSM states: IDLE, RD, CAP, WR, DONE.
  - IDLE -> START, COUNT != 0: go to WR if fill, RD if copy; busy = 1.
  - RD: present SRC, we = 0. When granted, go to CAP.
  - CAP: latch vram_rdata into the data register; go to WR. The capture happens even if the CPU owns the port that cycle.
  - WR: present DST with data (FILL or latched). When granted:
    - SRC/DST step by ±1 per DIR, wrapping modulo 8192;
    - COUNT decrements;
    - if COUNT was 1, go to DONE; else go to RD (copy) or stay in WR (fill).
  - DONE: busy = 0; IRQ <= IEN (IRQ set-and-clear in the same cycle: set wins); go to IDLE.
- Arbitration is combinational, with fixed CPU priority:
  - If cpu_vreq is high, the port carries the cpu_* signals and the engine stalls in RD/WR with no state change.
  - Otherwise the engine drives the port in RD/WR. In all other states vram_we = 0.
- Throughput with no CPU contention: fill = 1 byte/cycle; copy = 3 cycles/byte.
- Overlapping SRC/DST are copied literally in the programmed direction; no overlap correction.
- Working counters are separate copies of SRC/DST/COUNT. Programmed registers read back unchanged during and after the operation.
- rst_n asserted mid-operation: abort immediately, return to reset values, no further VRAM write.

Optional Feature:
- VPU_BLIT_KEY_EN defined:
  - $7 bit3 = KEY.
  - In copy mode with KEY = 1, a byte equal to FILL is skipped: WR advances pointers and count without asserting vram_we.
- Undefined: bit3 reads 0 and writes are ignored; copy always writes.

Decomposition:
- Shared package vpu_pkg:
  - blit state enum;
  - register offset constants (BLT_SRC_H … BLT_CTRL);
  - CTRL bit index constants;
  - VRAM_AW = 13.
- One sub-module, vpu_vram_arb: the combinational CPU-priority port mux, plus the grant signal to the engine.

Test Plan:
- Fill: DST = $0100, COUNT = 4, FILL = $AA, IEN = 1, START -> writes $AA to $0100–$0103 on 4 consecutive cycles; irq = 1; read $7 = $C0 and irq then drops.
- Copy with decrement and wrap: SRC = $0001, DST = $1000, COUNT = 3, DIR = 1 -> reads $0001, $0000, $1FFF; writes $1000, $0FFF, $0FFE with the matching data.
- CPU contention: hold cpu_vreq = 1 for 5 cycles during a fill -> port shows only CPU accesses; engine resumes with no lost or duplicated byte; total writes = COUNT.
- COUNT = 0, START with IEN = 1 -> no vram_we; busy stays 0; irq = 1 next cycle.
- Writes while BUSY: rewrite $3 and START mid-fill -> ignored; $3 readback unchanged; operation completes as programmed.
- Reset mid-copy: drop rst_n after 2 bytes -> vram_we = 0 immediately; all registers back at reset values; no IRQ.
